// File: rtl/code_memory_pkg.sv
// Shared types and constants for the parametrised code memory.
// default_image() supplies the power-on contents of both the BIOS and the user region.
package code_memory_pkg;

  localparam int DEF_INSTR_W    = 16;
  localparam int DEF_ADDR_W     = 6;
  localparam int DEF_BIOS_WORDS = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } ld_state_t;

  // Bit 32 is the multicycle flag; bits 31:0 hold the instruction payload,
  // which the caller truncates to its own INSTR_W.
  function automatic logic [32:0] default_image(input int unsigned idx,
                                                input int unsigned bios_words);
    logic [31:0] i;
    logic [32:0] w;
    i = idx;
    if (idx < bios_words) begin
      w = {i[0], 32'h0000_B000 + i};
    end else begin
      w = {i[1], 32'h0000_C000 | i};
    end
    return w;
  endfunction

endpackage

// File: rtl/code_mem_loader.sv
// Streaming block-load engine: walks the user region from ld_base, wrapping
// past the top back to the first user word, and hands each accepted beat to the array.
module code_mem_loader
  import code_memory_pkg::*;
#(
  parameter int INSTR_W    = DEF_INSTR_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DEPTH      = 2 ** ADDR_W,
  parameter int BIOS_WORDS = DEF_BIOS_WORDS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ld_start,
  input  logic [ADDR_W-1:0]  ld_base,
  input  logic [ADDR_W:0]    ld_count,
  input  logic               ld_valid,
  input  logic [INSTR_W:0]   ld_data,
  output logic               ld_ready,
  output logic               ld_busy,
  output logic               ld_done,
  output logic               ld_err,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W:0]   mem_data
);

  localparam logic [ADDR_W:0]   BIOS_L    = (ADDR_W + 1)'(BIOS_WORDS);
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] WRAP_ADDR = ADDR_W'(BIOS_WORDS);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

  ld_state_t         state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W:0]   cnt_reg, cnt_next;
  logic              ld_err_reg, ld_err_next;
  logic              base_bad;

  assign base_bad = ({1'b0, ld_base} < BIOS_L) || ({1'b0, ld_base} >= DEPTH_L);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      cnt_reg    <= '0;
      ld_err_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      cnt_reg    <= cnt_next;
      ld_err_reg <= ld_err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    cnt_next    = cnt_reg;
    ld_err_next = 1'b0;
    mem_we      = 1'b0;
    ld_ready    = 1'b0;
    ld_busy     = 1'b0;
    ld_done     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ld_start) begin
          if (base_bad) begin
            ld_err_next = 1'b1;
          end else if (ld_count == '0) begin
            state_next = DONE;
          end else begin
            addr_next  = ld_base;
            cnt_next   = ld_count;
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        ld_busy  = 1'b1;
        if (ld_valid) begin
          mem_we    = 1'b1;
          addr_next = (addr_reg == LAST_ADDR) ? WRAP_ADDR : addr_reg + 1'b1;
          cnt_next  = cnt_reg - 1'b1;
          if (cnt_reg == CNT_ONE) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        ld_done    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_addr = addr_reg;
  assign mem_data = ld_data;
  assign ld_err   = ld_err_reg;

endmodule

// File: rtl/code_memory_param.sv
// Parametrised code memory: write-protected BIOS, user region fed by direct
// writes or the block loader, and a run-gated registered fetch port.
module code_memory_param
  import code_memory_pkg::*;
#(
  parameter int INSTR_W    = DEF_INSTR_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DEPTH      = 2 ** ADDR_W,
  parameter int BIOS_WORDS = DEF_BIOS_WORDS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [INSTR_W:0]   instr,
  output logic               multicycle_flag,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [INSTR_W:0]   wr_data,
  output logic               wr_err,
  input  logic               ld_start,
  input  logic [ADDR_W-1:0]  ld_base,
  input  logic [ADDR_W:0]    ld_count,
  input  logic               ld_valid,
  input  logic [INSTR_W:0]   ld_data,
  output logic               ld_ready,
  output logic               ld_busy,
  output logic               ld_done,
  output logic               ld_err
);

  localparam logic [ADDR_W:0] BIOS_L  = (ADDR_W + 1)'(BIOS_WORDS);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [INSTR_W:0]  mem      [DEPTH];
  logic [INSTR_W:0]  def_word [DEPTH];

  logic              ld_we;
  logic [ADDR_W-1:0] ld_waddr;
  logic [INSTR_W:0]  ld_wdata;
  logic              wr_bad, dir_we, mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [INSTR_W:0]  mem_wdata;
  logic              rd_in_range;
  logic [INSTR_W:0]  instr_reg;
  logic              flag_reg, wr_err_reg;

  code_mem_loader #(
    .INSTR_W    (INSTR_W),
    .ADDR_W     (ADDR_W),
    .DEPTH      (DEPTH),
    .BIOS_WORDS (BIOS_WORDS)
  ) u_loader (
    .clock    (clock),
    .reset    (reset),
    .ld_start (ld_start),
    .ld_base  (ld_base),
    .ld_count (ld_count),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .ld_busy  (ld_busy),
    .ld_done  (ld_done),
    .ld_err   (ld_err),
    .mem_we   (ld_we),
    .mem_addr (ld_waddr),
    .mem_data (ld_wdata)
  );

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_default
      localparam logic [32:0] IMG = default_image(unsigned'(gi), unsigned'(BIOS_WORDS));
      assign def_word[gi] = {IMG[32], IMG[INSTR_W-1:0]};
    end
  endgenerate

  // A busy loader owns the array, so direct writes are refused rather than arbitrated.
  assign wr_bad    = ({1'b0, wr_addr} < BIOS_L) || ({1'b0, wr_addr} >= DEPTH_L) || ld_busy;
  assign dir_we    = run && wr_en && !wr_bad;
  assign mem_we    = ld_we || dir_we;
  assign mem_waddr = ld_we ? ld_waddr : wr_addr;
  assign mem_wdata = ld_we ? ld_wdata : wr_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= def_word[i];
      end
    end else if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);

  // Non-blocking update of mem gives read-first behaviour on a same-address write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr_reg  <= '0;
      flag_reg   <= 1'b0;
      wr_err_reg <= 1'b0;
    end else begin
      wr_err_reg <= run && wr_en && wr_bad;
      if (run) begin
        if (rd_in_range) begin
          instr_reg <= mem[rd_addr];
          flag_reg  <= mem[rd_addr][INSTR_W];
        end else begin
          instr_reg <= '0;
          flag_reg  <= 1'b0;
        end
      end
    end
  end

  assign instr           = instr_reg;
  assign multicycle_flag = flag_reg;
  assign wr_err          = wr_err_reg;

endmodule

// File: tb/tb_code_memory_param.sv
// Directed bench for code_memory_param: fetch, BIOS protection, read-first,
// block load with stalls and wrap, load errors, and reset during a load.
module tb_code_memory_param;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic [5:0]  rd_addr = '0;
  logic [16:0] instr;
  logic        multicycle_flag;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [16:0] wr_data = '0;
  logic        wr_err;
  logic        ld_start = 1'b0;
  logic [5:0]  ld_base = '0;
  logic [6:0]  ld_count = '0;
  logic        ld_valid = 1'b0;
  logic [16:0] ld_data = '0;
  logic        ld_ready, ld_busy, ld_done, ld_err;

  int tests_run = 0;
  int tests_failed = 0;

  code_memory_param dut (
    .clock           (clock),
    .reset           (reset),
    .run             (run),
    .rd_addr         (rd_addr),
    .instr           (instr),
    .multicycle_flag (multicycle_flag),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_err          (wr_err),
    .ld_start        (ld_start),
    .ld_base         (ld_base),
    .ld_count        (ld_count),
    .ld_valid        (ld_valid),
    .ld_data         (ld_data),
    .ld_ready        (ld_ready),
    .ld_busy         (ld_busy),
    .ld_done         (ld_done),
    .ld_err          (ld_err)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic read_word(input logic [5:0] a, input logic [16:0] exp, input string tag);
    rd_addr = a;
    step();
    check(tag, 32'(instr), 32'(exp));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int cyc;
    logic [16:0] d;

    // Reset state
    #2 reset = 1'b1;
    #2;
    check("rst_instr", 32'(instr), 32'h0);
    check("rst_flag", 32'(multicycle_flag), 32'h0);
    check("rst_busy", 32'(ld_busy), 32'h0);
    check("rst_ready", 32'(ld_ready), 32'h0);
    check("rst_done", 32'(ld_done), 32'h0);
    check("rst_wr_err", 32'(wr_err), 32'h0);
    step();
    step();
    reset = 1'b0;

    // Fetch and run gating
    run = 1'b1;
    rd_addr = 6'd0;
    step();
    check("fetch0_instr", 32'(instr), 32'h0B000);
    check("fetch0_flag", 32'(multicycle_flag), 32'h0);
    run = 1'b0;
    rd_addr = 6'd5;
    step();
    check("hold_instr", 32'(instr), 32'h0B000);
    run = 1'b1;
    step();
    check("fetch5_instr", 32'(instr), 32'h1B005);
    check("fetch5_flag", 32'(multicycle_flag), 32'h1);

    // BIOS protection
    wr_en = 1'b1;
    wr_addr = 6'd10;
    wr_data = 17'h1ABCD;
    step();
    check("bios_wr_err", 32'(wr_err), 32'h1);
    wr_en = 1'b0;
    read_word(6'd10, 17'h0B00A, "bios_unchanged");
    check("bios_wr_err_pulse", 32'(wr_err), 32'h0);

    // Write ignored while run=0
    run = 1'b0;
    wr_en = 1'b1;
    wr_addr = 6'd36;
    wr_data = 17'h01111;
    step();
    check("norun_wr_err", 32'(wr_err), 32'h0);
    wr_en = 1'b0;
    run = 1'b1;
    read_word(6'd36, 17'h0C024, "norun_unchanged");

    // User write with read-first
    rd_addr = 6'd40;
    wr_en = 1'b1;
    wr_addr = 6'd40;
    wr_data = 17'h1ABCD;
    step();
    check("rf_old", 32'(instr), 32'h0C028);
    check("user_wr_err", 32'(wr_err), 32'h0);
    wr_en = 1'b0;
    step();
    check("rf_new", 32'(instr), 32'h1ABCD);
    check("rf_new_flag", 32'(multicycle_flag), 32'h1);

    // Block load with stalls and wrap-around
    ld_base = 6'd60;
    ld_count = 7'd6;
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    check("load_busy", 32'(ld_busy), 32'h1);
    check("load_ready", 32'(ld_ready), 32'h1);
    sent = 0;
    cyc = 0;
    while (sent < 6 && cyc < 40) begin
      ld_valid = (cyc % 2 == 0);
      d = 17'h12340 + 17'(sent);
      ld_data = d;
      step();
      if (ld_valid) sent++;
      if (sent < 6) begin
        check("load_busy_mid", 32'(ld_busy), 32'h1);
        check("load_done_early", 32'(ld_done), 32'h0);
      end
      cyc++;
    end
    ld_valid = 1'b0;
    check("load_beats", 32'(sent), 32'd6);
    check("load_done", 32'(ld_done), 32'h1);
    check("load_done_busy", 32'(ld_busy), 32'h0);
    check("load_done_ready", 32'(ld_ready), 32'h0);
    step();
    check("load_done_pulse", 32'(ld_done), 32'h0);
    read_word(6'd60, 17'h12340, "load_w60");
    read_word(6'd61, 17'h12341, "load_w61");
    read_word(6'd62, 17'h12342, "load_w62");
    read_word(6'd63, 17'h12343, "load_w63");
    read_word(6'd32, 17'h12344, "load_w32");
    read_word(6'd33, 17'h12345, "load_w33");
    read_word(6'd34, 17'h1C022, "load_w34_untouched");

    // Bad base
    ld_base = 6'd3;
    ld_count = 7'd2;
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    check("bad_base_err", 32'(ld_err), 32'h1);
    check("bad_base_busy", 32'(ld_busy), 32'h0);
    step();
    check("bad_base_err_pulse", 32'(ld_err), 32'h0);

    // Zero-length load
    ld_base = 6'd40;
    ld_count = 7'd0;
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    check("zero_done", 32'(ld_done), 32'h1);
    check("zero_busy", 32'(ld_busy), 32'h0);
    step();
    check("zero_done_pulse", 32'(ld_done), 32'h0);
    read_word(6'd40, 17'h1ABCD, "zero_nochange");

    // Direct write during LOAD
    ld_base = 6'd45;
    ld_count = 7'd2;
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    check("busy_before_wr", 32'(ld_busy), 32'h1);
    wr_en = 1'b1;
    wr_addr = 6'd50;
    wr_data = 17'h1ABCD;
    step();
    check("busy_wr_err", 32'(wr_err), 32'h1);
    wr_en = 1'b0;
    ld_valid = 1'b1;
    ld_data = 17'h00045;
    step();
    check("busy_wr_err_pulse", 32'(wr_err), 32'h0);
    step();
    ld_valid = 1'b0;
    check("short_load_done", 32'(ld_done), 32'h1);
    read_word(6'd50, 17'h1C032, "busy_wr_unchanged");
    read_word(6'd46, 17'h00045, "short_load_w46");

    // Reset in the middle of a load
    ld_base = 6'd40;
    ld_count = 7'd5;
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    ld_valid = 1'b1;
    ld_data = 17'h05555;
    step();
    step();
    ld_valid = 1'b0;
    check("midload_busy", 32'(ld_busy), 32'h1);
    reset = 1'b1;
    #2;
    check("midrst_busy", 32'(ld_busy), 32'h0);
    check("midrst_instr", 32'(instr), 32'h0);
    check("midrst_done", 32'(ld_done), 32'h0);
    @(posedge clock);
    #1 reset = 1'b0;
    read_word(6'd40, 17'h0C028, "midrst_w40");
    check("midrst_done_a", 32'(ld_done), 32'h0);
    read_word(6'd41, 17'h0C029, "midrst_w41");
    check("midrst_done_b", 32'(ld_done), 32'h0);
    check("midrst_busy_b", 32'(ld_busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
